// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM state encoding, default sizing and the pointer-width helper.
package arb_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int c;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    c      = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!valid && req[c[PW-1:0]]) begin
        valid             = 1'b1;
        idx               = c[PW-1:0];
        winner[c[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// N requesters compete round-robin for one W-bit register; each granted
// write commits (or is cancelled/withdrawn) one cycle after the grant.
module shared_reg_arbiter
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wr_data,
  input  logic           clr,
  output logic [N-1:0]   gnt,
  output logic           ack,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int PW = ptr_w(N);

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [PW-1:0] win, win_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic          ack_nxt;
  logic          q_ld, q_clr;

  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      win   <= '0;
      ptr   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      win   <= win_nxt;
      ptr   <= ptr_nxt;
      ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    win_nxt   = win;
    ptr_nxt   = ptr;
    ack_nxt   = 1'b0;
    q_ld      = 1'b0;
    q_clr     = clr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_oh;
          win_nxt   = pick_idx;
        end
      end
      GRANT: begin
        // Every exit advances the pointer, even when the write is dropped.
        state_nxt = IDLE;
        ptr_nxt   = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        if (!clr && req[win]) begin
          q_ld    = 1'b1;
          ack_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared register: clear has priority over a granted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (q_clr) q <= '0;
    else if (q_ld)  q <= wr_data[int'(win)*W +: W];
  end

  assign busy = (state == GRANT);

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters (2..8).
REQ-002 Parameter W, default 8: width of the shared register.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately, regardless of clk.
REQ-005 req  input  N  per-requester write request; level-sensitive.
REQ-006 wr_data  input  N*W  requester i's data on bits [i*W +: W].
REQ-007 clr  input  1  synchronous clear of the shared register.
REQ-008 gnt  output  N  one-hot grant, registered; all-zero when idle.
REQ-009 ack  output  1  one-cycle pulse: the granted write has committed.
REQ-010 q  output  W  shared register contents, registered.
REQ-011 busy  output  1  high while state is GRANT.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 IDLE, no req bit set: stay in IDLE; gnt=0.
REQ-014 IDLE, any req bit set: at the next edge, set gnt to the winner, latch the winner index, go to GRANT.
REQ-015 Winner: the first set req bit searching upward from ptr, wrapping N-1 -> 0.
REQ-016 ptr SHALL be a log2(N)-bit round-robin pointer.
REQ-017 GRANT, req[winner]=1, clr=0: at the edge, q <= wr_data[winner], ack=1 in the following cycle, go to IDLE.
REQ-018 GRANT, req[winner]=0 (requester withdrew): q unchanged, no ack, go to IDLE.
REQ-019 GRANT, clr=1: q <= 0, write cancelled, no ack, go to IDLE.
REQ-020 On every exit from GRANT, ptr <= (winner+1) mod N, including cancelled writes.
REQ-021 IDLE, clr=1: q <= 0 at the edge; arbitration proceeds in parallel.
REQ-022 Latency: a req first seen in IDLE at edge E gives gnt high after E, q updated and ack high after E+1.
REQ-023 Throughput: at most one committed write per 2 cycles.
REQ-024 A requester SHALL hold req and wr_data stable until ack, or until gnt drops.
REQ-025 gnt SHALL never have more than one bit set; gnt and busy deassert in the cycle ack is high.
REQ-026 Requests arriving during GRANT SHALL be considered only at the next IDLE evaluation.

Reset
REQ-027 rst=0 SHALL asynchronously force: state=IDLE, gnt=0, ack=0, busy=0, q=0, ptr=0.
REQ-028 Reset asserted mid-GRANT SHALL abort the write: no q update, no ack.
REQ-029 After rst deasserts, arbitration SHALL resume at the first rising clk edge with ptr=0.

Structure
REQ-030 The state encoding (IDLE=0, GRANT=1) SHALL live in shared package arb_pkg, along with default N/W constants.
REQ-031 Round-robin winner selection SHALL be a separate combinational sub-module rr_pick (inputs: req, ptr; outputs: one-hot winner, index, valid).
REQ-032 The q storage SHALL be a plain W-bit register block inside shared_reg_arbiter.

Verification
REQ-033 Reset: drive rst=0 mid-GRANT with req=4'b0010 -> gnt=0, q=8'h00, ack never pulses; after release, req=4'b0010 -> gnt=4'b0010.
REQ-034 Single write: req=4'b0001, data0=8'hA5 -> gnt=4'b0001 one cycle; next cycle q=8'hA5, ack=1.
REQ-035 Fairness: req=4'b1111 held, data i=8'h10+i -> commit order 0,1,2,3,0; q values 10,11,12,13,10; ack every 2nd cycle.
REQ-036 Wrap: ptr=3, req=4'b0101 -> requester 0 wins, then ptr=1 -> requester 2 wins next.
REQ-037 Withdraw: requester 2 granted, drops req in GRANT -> q unchanged, no ack, ptr=3.
REQ-038 clr in GRANT: requester 1 granted with 8'h7E, clr=1 -> q=8'h00, no ack, ptr=2.
